// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Instruction fetch unit with a circular prefetch queue.
//                Issues one word request at a time to instruction memory and
//                buffers returned words (with their addresses) for the
//                decode stage. Supports a flush/redirect of the fetch stream.
//                Optional same-cycle bypass of a returned word to the decode
//                stage when the queue is empty: define IFQ_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRValid,
  input  logic [31:0] imemRData,
  output logic        instrValid,
  output logic [31:0] instrCode,
  output logic [31:0] instrPC,
  input  logic        instrReady,
  input  logic        redirectValid,
  input  logic [31:0] redirectPC
);

  localparam int                 c_PTR_W     = $clog2(DEPTH);
  localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  localparam logic [1:0] c_FETCH   = 2'd0;
  localparam logic [1:0] c_WAIT    = 2'd1;
  localparam logic [1:0] c_DISCARD = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_stateNext;
  logic               r_reqEn;
  logic [31:0]        r_fetchPC;
  logic [31:0]        r_reqPC;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic [63:0]        r_mem [DEPTH];
  logic [31:0]        r_lastCode;
  logic [31:0]        r_lastPC;

  logic               w_grant;
  logic               w_empty;
  logic               w_rspAccept;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_redirTarget;
  logic               w_unused;

  // Low address bits of a redirect target are architecturally ignored.
  assign w_redirTarget = {redirectPC[31:2], 2'b00};
  assign w_unused      = &{1'b0, redirectPC[1:0]};

  assign w_grant = imemReq & imemGnt;
  assign w_empty = (r_count == '0);

  // A response is only kept when it belongs to the live fetch stream.
  assign w_rspAccept = (r_state == c_WAIT) & imemRValid & ~redirectValid;

`ifdef IFQ_BYPASS_EN
  // A word bypassed straight to a ready consumer never enters the queue.
  assign w_push = w_rspAccept & ~(w_empty & instrReady);
`else
  assign w_push = w_rspAccept;
`endif
  // Redirect wins over pop: the flushed queue shows nothing afterwards.
  assign w_pop  = ~w_empty & instrReady & ~redirectValid;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // FSM next-state: one outstanding request; a redirect while waiting must
  // swallow the stale response before fetching resumes.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_FETCH: begin
        if (w_grant) begin
          w_stateNext = c_WAIT;
        end
      end
      c_WAIT: begin
        if (imemRValid) begin
          w_stateNext = c_FETCH;
        end else if (redirectValid) begin
          w_stateNext = c_DISCARD;
        end
      end
      c_DISCARD: begin
        if (imemRValid) begin
          w_stateNext = c_FETCH;
        end
      end
      default: w_stateNext = c_FETCH;
    endcase
  end

  // FSM outputs: request only with a free queue slot and no redirect pending.
  always_comb begin
    imemReq  = r_reqEn & (r_state == c_FETCH) & (r_count < c_DEPTH_CNT) & ~redirectValid;
    imemAddr = r_fetchPC;
  end

  // Fetch address, queue pointers/occupancy and held output values
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_reqEn    <= 1'b0;
      r_fetchPC  <= RESET_PC;
      r_reqPC    <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_lastCode <= 32'h0;
      r_lastPC   <= 32'h0;
    end else begin
      r_reqEn    <= 1'b1;
      r_lastCode <= instrCode;
      r_lastPC   <= instrPC;
      if (redirectValid) begin
        r_fetchPC <= w_redirTarget;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
      end else begin
        if (w_grant) begin
          r_reqPC   <= r_fetchPC;
          r_fetchPC <= r_fetchPC + 32'd4;
        end
        if (w_push) begin
          r_tail <= r_tail + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage: {address, instruction word}; contents are don't-care
  // while the slot is unoccupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= {r_reqPC, imemRData};
    end
  end

`ifdef IFQ_BYPASS_EN
  // Decode-side outputs: head entry, same-cycle bypass, or the held value.
  always_comb begin
    instrValid = ~w_empty;
    instrCode  = r_lastCode;
    instrPC    = r_lastPC;
    if (!w_empty) begin
      instrCode = r_mem[r_head][31:0];
      instrPC   = r_mem[r_head][63:32];
    end else if (w_rspAccept) begin
      instrValid = 1'b1;
      instrCode  = imemRData;
      instrPC    = r_reqPC;
    end
  end
`else
  // Decode-side outputs: head entry, or the held value while empty.
  always_comb begin
    instrValid = ~w_empty;
    instrCode  = r_lastCode;
    instrPC    = r_lastPC;
    if (!w_empty) begin
      instrCode = r_mem[r_head][31:0];
      instrPC   = r_mem[r_head][63:32];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Self-checking bench for instr_fetch_queue: cycle vector
//                table for reset/redirect corners plus a memory model with a
//                scoreboard for streaming, back-pressure and address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int NVEC = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRValid;
  logic [31:0] imemRData;
  logic        instrValid;
  logic [31:0] instrCode;
  logic [31:0] instrPC;
  logic        instrReady;
  logic        redirectValid;
  logic [31:0] redirectPC;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRValid(imemRValid), .imemRData(imemRData),
    .instrValid(instrValid), .instrCode(instrCode), .instrPC(instrPC),
    .instrReady(instrReady),
    .redirectValid(redirectValid), .redirectPC(redirectPC)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_code;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [63:0] sb [$];
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_hs      = 0;
  int          n_grants  = 0;
  int          pend_cnt  = 0;
  bit          lat_rand  = 1'b0;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic r, input logic g, input logic v, input logic [31:0] d,
                              input logic y, input logic x, input logic [31:0] p,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ec, input logic [31:0] ep);
    return '{r, g, v, d, y, x, p, eq, ea, ev, ec, ep};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // One cycle with the memory model and scoreboard monitor active. Called
  // just after a rising edge once this cycle's inputs have been applied.
  task automatic run_cycle();
    logic [63:0] e;
    @(negedge clk);
    if (instrValid && instrReady) begin
      n_hs++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb.instrPC", instrPC, e[63:32]);
        chk("sb.instrCode", instrCode, e[31:0]);
      end else begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: actual instrPC %h required no instruction", instrPC);
      end
    end
    if (imemReq && imemGnt) begin
      n_grants++;
      chk("grant.imemAddr", imemAddr, exp_fetch);
      chk("grant.one_outstanding", pend_cnt, 0);
      chk("grant.credit", 32'((n_grants - n_hs) <= DEPTH), 32'd1);
      pend_addr = exp_fetch;
      pend_cnt  = lat_rand ? int'($urandom_range(1, 3)) : 1;
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    #1;
    imemRValid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imemRValid = 1'b1;
        imemRData  = mdata(pend_addr);
        sb.push_back({pend_addr, mdata(pend_addr)});
      end
    end
  endtask

  task automatic drain();
    imemGnt    = 1'b0;
    instrReady = 1'b1;
    for (int c = 0; c < 60 && (pend_cnt != 0 || sb.size() != 0); c++) run_cycle();
    chk("drain.sb_size", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b0; imemGnt = 1'b0; imemRValid = 1'b0; imemRData = 32'h0;
    instrReady = 1'b0; redirectValid = 1'b0; redirectPC = 32'h0;

    //            rst gnt rv  rdata          rdy redir rpc            req addr           val    code                      pc
    vecs[0]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0,    32'h0,                    32'h0);
    vecs[1]  = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0,    32'h0,                    32'h0);
    vecs[2]  = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,          0,    32'h0,                    32'h0);
    vecs[3]  = mk(1, 1, 1, 32'h13,         1, 0, 32'h0,          0, 32'h4,          BYP,  BYP ? 32'h13 : 32'h0,     32'h0);
    vecs[4]  = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,          !BYP, 32'h13,                   32'h0);
    vecs[5]  = mk(1, 1, 1, 32'hBAD0_0001,  1, 1, 32'h203,        0, 32'h8,          !BYP, 32'h13,                   32'h0);
    vecs[6]  = mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,        0,    32'h13,                   32'h0);
    vecs[7]  = mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,        0,    32'h13,                   32'h0);
    vecs[8]  = mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,        0,    32'h13,                   32'h0);
    vecs[9]  = mk(1, 1, 0, 32'h0,          1, 1, 32'h103,        0, 32'h204,        0,    32'h13,                   32'h0);
    vecs[10] = mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,        0,    32'h13,                   32'h0);
    vecs[11] = mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,        0,    32'h13,                   32'h0);
    vecs[12] = mk(1, 1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          0, 32'h100,        0,    32'h13,                   32'h0);
    vecs[13] = mk(1, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h100,        0,    32'h13,                   32'h0);
    vecs[14] = mk(1, 1, 1, 32'h513,        0, 0, 32'h0,          0, 32'h104,        BYP,  BYP ? 32'h513 : 32'h13,   BYP ? 32'h100 : 32'h0);
    vecs[15] = mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,        1,    32'h513,                  32'h100);
    vecs[16] = mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,        0,    32'h513,                  32'h100);
    vecs[17] = mk(1, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,        0,    32'h513,                  32'h100);
    vecs[18] = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h108,        0,    32'h513,                  32'h100);
    vecs[19] = mk(1, 0, 1, 32'h1234_5678,  1, 0, 32'h0,          0, 32'h0,          0,    32'h0,                    32'h0);
    vecs[20] = mk(1, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0,    32'h0,                    32'h0);

    repeat (2) @(posedge clk);

    // Cycle-accurate vectors: reset, request gating, redirect corners,
    // response latency, output hold and reset during an outstanding fetch.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      rst           = vecs[i].rst;
      imemGnt       = vecs[i].gnt;
      imemRValid    = vecs[i].rv;
      imemRData     = vecs[i].rdata;
      instrReady    = vecs[i].rdy;
      redirectValid = vecs[i].redir;
      redirectPC    = vecs[i].rpc;
      @(negedge clk);
      chk($sformatf("v%0d.imemReq", i),    imemReq,    vecs[i].e_req);
      chk($sformatf("v%0d.imemAddr", i),   imemAddr,   vecs[i].e_addr);
      chk($sformatf("v%0d.instrValid", i), instrValid, vecs[i].e_val);
      chk($sformatf("v%0d.instrCode", i),  instrCode,  vecs[i].e_code);
      chk($sformatf("v%0d.instrPC", i),    instrPC,    vecs[i].e_pc);
    end

    @(posedge clk);
    #1;
    rst = 1'b1; redirectValid = 1'b0; imemRValid = 1'b0;
    imemGnt = 1'b1; instrReady = 1'b1; lat_rand = 1'b0;

    // Streaming from RESET_PC with immediate grant and 1-cycle response.
    exp_fetch = RESET_PC; n_hs = 0; n_grants = 0;
    for (int c = 0; c < 40 && n_hs < 4; c++) run_cycle();
    chk("stream.handshakes", n_hs, 4);
    drain();

    // Back-pressure: queue fills to DEPTH, then one request per pop.
    imemGnt = 1'b1; instrReady = 1'b0; n_hs = 0; n_grants = 0;
    repeat (30) run_cycle();
    chk("full.grants", n_grants, DEPTH);
    chk("full.imemReq", imemReq, 0);
    chk("full.instrValid", instrValid, 1);
    instrReady = 1'b1;
    repeat (16) run_cycle();
    chk("full.resumed", 32'(n_grants > DEPTH), 32'd1);
    drain();

    // Address wrap at the top of memory plus queue pointer wrap under
    // random back-pressure and response latency.
    imemGnt = 1'b0; redirectValid = 1'b1; redirectPC = 32'hFFFF_FFFA;
    run_cycle();
    redirectValid = 1'b0; imemGnt = 1'b1; lat_rand = 1'b1;
    exp_fetch = 32'hFFFF_FFF8; n_hs = 0; n_grants = 0;
    for (int c = 0; c < 400 && n_hs < 12; c++) begin
      instrReady = 1'($urandom_range(0, 1));
      run_cycle();
    end
    chk("wrap.handshakes", n_hs, 12);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-005 imemReq  output  1  fetch request to instruction memory.
REQ-006 imemAddr  output  32  byte address of the requested word, bits [1:0] always 0.
REQ-007 imemGnt  input  1  memory accepts the request in the current cycle.
REQ-008 imemRValid  input  1  read data valid.
REQ-009 imemRData  input  32  instruction word returned.
REQ-010 instrValid  output  1  instrCode/instrPC hold a valid instruction.
REQ-011 instrCode  output  32  instruction to the datapath decode/register-file stage.
REQ-012 instrPC  output  32  address of instrCode.
REQ-013 instrReady  input  1  datapath consumes the instruction this cycle.
REQ-014 redirectValid  input  1  flush queue and restart fetch.
REQ-015 redirectPC  input  32  new fetch address; bits [1:0] ignored and forced to 0.

Function
REQ-016 The block SHALL implement an FSM with states FETCH, WAIT, DISCARD.
REQ-017 FETCH: imemReq=1 iff count+outstanding < DEPTH and redirectValid=0; imemReq&imemGnt -> WAIT, fetchPC increments by 4.
REQ-018 WAIT: imemReq=0; imemRValid -> write {fetchPC_prev, imemRData} to tail, go FETCH.
REQ-019 At most one request SHALL be outstanding; imemAddr SHALL hold stable while imemReq=1 and imemGnt=0.
REQ-020 Memory response latency SHALL be at least 1 cycle after grant; any number of wait cycles is tolerated.
REQ-021 Queue SHALL be a circular buffer with log2(DEPTH)-bit head/tail pointers wrapping DEPTH-1 -> 0 and a count 0..DEPTH.
REQ-022 instrValid = (count != 0); instrCode/instrPC = head entry; pop on instrValid & instrReady.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; push at count==DEPTH SHALL never occur (credit rule REQ-017).
REQ-024 Without bypass, a returned word SHALL appear on instrValid the cycle after imemRValid.
REQ-025 fetchPC SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-026 redirectValid SHALL: empty the queue (count=0, head=tail) next cycle, set fetchPC = {redirectPC[31:2],2'b00}, deassert imemReq that cycle.
REQ-027 Redirect in WAIT without same-cycle imemRValid -> DISCARD; DISCARD drops the next imemRValid, then -> FETCH.
REQ-028 Redirect with same-cycle imemRValid SHALL drop that response and go FETCH.
REQ-029 Redirect has priority over pop: instrReady in the redirect cycle still pops nothing visible afterwards (queue empty).
REQ-030 instrCode/instrPC SHALL hold their last value when instrValid=0.

Reset
REQ-031 rst=0 at posedge clk SHALL force: state FETCH, count 0, pointers 0, fetchPC=RESET_PC, imemReq 0, imemAddr RESET_PC, instrValid 0, instrCode 0, instrPC 0.
REQ-032 imemReq SHALL first assert in the first cycle rst is sampled high (registered request gating).
REQ-033 Reset mid-WAIT SHALL abandon the outstanding request; a late imemRValid after reset SHALL be ignored until the first new grant.

Configuration
REQ-034 Macro IFQ_BYPASS_EN defined: when count==0 and imemRValid (not discarded, no redirect), instrValid=1 same cycle with instrCode=imemRData, instrPC=response address; if instrReady the word is not stored, else it is pushed.
REQ-035 IFQ_BYPASS_EN undefined: no combinational path from imem* inputs to instr* outputs; behaviour per REQ-024.

Verification
REQ-036 Reset release, RESET_PC=0, memory grants immediately, 1-cycle response, instrReady=1 -> instrPC sequence 0,4,8,12 with matching imemRData.
REQ-037 instrReady=0, DEPTH=4 -> exactly 4 grants, imemReq stays 0, count=4; raise instrReady -> one new request per pop.
REQ-038 Redirect to 32'h0000_0103 while WAIT, response 0xDEAD_BEEF arrives 3 cycles later -> word dropped, next imemAddr=32'h0000_0100, first instrPC=0x100.
REQ-039 Redirect coincident with imemRValid and instrValid=1 -> next cycle instrValid=0, no push, imemAddr=redirect target.
REQ-040 fetchPC=32'hFFFF_FFFC granted -> next imemAddr=0; queue wrap with 10 consecutive pushes/pops keeps order.
REQ-041 IFQ_BYPASS_EN, empty queue, imemRValid with 0x0000_0013 -> instrValid=1, instrCode=0x0000_0013 same cycle; undefined -> one cycle later.
